data_sync_mcp: RTL and testbench
================================

# data_sync_mcp

Multi-bit clock-domain-crossing synchroniser using the multi-cycle-path (MCP) formulation. A single-bit qualifier (BUS_EN) is synchronised through a parametrised flop chain. A pulse generator then captures a quasi-static data bus into the destination domain. It sits at every multi-bit crossing of the system (register-file/ALU side to UART side and back), replacing per-bit synchronisation of buses, which is unsafe.

## Interface

Parameters:
- NUM_STAGES, 2 — synchroniser depth on BUS_EN; legal range 2–8
- BUS_WIDTH, 8 — data bus width; legal range 1–32
- EN_MODE, 0 — 0: level qualifier (new word on BUS_EN rising edge); 1: toggle qualifier (new word on every BUS_EN transition)

Ports:
- CLK  in  1  destination-domain clock
- RST_n  in  1  reset, asynchronous, active-low
- UNSYNC_BUS  in  BUS_WIDTH  source-domain data; stable while qualifier in flight
- BUS_EN  in  1  source-domain qualifier, asynchronous to CLK
- SYNC_BUS  out  BUS_WIDTH  captured data, registered
- ENABLE_PULSE  out  1  one-cycle strobe, coincident with SYNC_BUS update
- SYNC_VALID  out  1  held-valid flag (DATA_SYNC_HOLD_EN only)
- SYNC_ACK  in  1  consumer acknowledge (DATA_SYNC_HOLD_EN only)
- OVERRUN  out  1  sticky lost-word flag (DATA_SYNC_HOLD_EN only)

## Operation

- Sync chain: NUM_STAGES flops on BUS_EN; last stage feeds edge register en_q.
- Pulse detect (combinational):
  - EN_MODE=0: pulse = sync_out & ~en_q
  - EN_MODE=1: pulse = sync_out ^ en_q
- Capture:
  - On a clock edge with pulse=1: SYNC_BUS <= UNSYNC_BUS and ENABLE_PULSE <= 1.
  - Otherwise SYNC_BUS holds and ENABLE_PULSE <= 0.
  - UNSYNC_BUS is never synchronised per bit; the source guarantees stability from the BUS_EN change until NUM_STAGES+1 CLK cycles later.
- EN_MODE=0, BUS_EN held high for many cycles: exactly one pulse. Must return low for at least NUM_STAGES+1 CLK cycles before the next word.
- EN_MODE=1: each transition is one word. Transitions closer than NUM_STAGES+1 cycles are not supported.
- Reset clears all flops: chain, en_q, SYNC_BUS=0, ENABLE_PULSE=0, SYNC_VALID=0, OVERRUN=0.
- Reset mid-transfer aborts the word; no pulse is produced for a qualifier edge captured before reset.
- BUS_EN=1 at reset release is seen as an edge in both modes and yields one pulse. The source holds BUS_EN=0 across reset.

## Timing

- E0 = first CLK rising edge that samples the new BUS_EN value.
- sync_out changes at edge E0+NUM_STAGES-1.
- SYNC_BUS and ENABLE_PULSE update at edge E0+NUM_STAGES.
- ENABLE_PULSE stays high exactly one cycle.
- Latency from BUS_EN change to ENABLE_PULSE: NUM_STAGES to NUM_STAGES+1 cycles, depending on phase.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- Macro: DATA_SYNC_HOLD_EN.
- Defined: adds the SYNC_VALID / SYNC_ACK / OVERRUN ports and the held-valid handshake.
  - SYNC_VALID is set at the capture edge and cleared at the first edge sampling SYNC_ACK=1 with no new pulse.
  - Pulse and SYNC_ACK in the same cycle: new word loads, SYNC_VALID stays 1, no overrun.
  - Pulse while SYNC_VALID=1 and SYNC_ACK=0: newest word overwrites SYNC_BUS and OVERRUN sets, sticky until RST_n.
  - SYNC_ACK while SYNC_VALID=0 is ignored.
- Undefined: these three ports are absent. SYNC_BUS holds the last word indefinitely, and consumers use ENABLE_PULSE only.

## Test plan

- Reset value check:
  - Stimulus: RST_n=0 with BUS_EN=0 and UNSYNC_BUS=8'hFF.
  - Required: SYNC_BUS=0, ENABLE_PULSE=0, SYNC_VALID=0, OVERRUN=0 throughout reset.
- Single word, level mode:
  - Stimulus: NUM_STAGES=2, EN_MODE=0, UNSYNC_BUS=8'hA5, BUS_EN raised at E0 and held 10 cycles.
  - Required: SYNC_BUS=8'hA5 and ENABLE_PULSE=1 at E0+2 only; no second pulse.
- Toggle mode, back to back:
  - Stimulus: NUM_STAGES=3, EN_MODE=1, words 8'h11, 8'h22, 8'h33, with BUS_EN toggled every 5 cycles.
  - Required: three single-cycle pulses, each 3 edges after its sampling edge, with SYNC_BUS taking 11, 22, 33 in order.
- Depth sweep:
  - Stimulus: NUM_STAGES 2, 4 and 8, with BUS_WIDTH=1 and 32.
  - Required: latency equals NUM_STAGES edges from E0 for 50 random words, with data matching.
- HOLD_EN handshake:
  - Stimulus: capture 8'h5A with SYNC_ACK=0, then capture 8'hC3.
  - Required: SYNC_BUS=8'hC3, OVERRUN=1 (sticky); SYNC_ACK=1 then clears SYNC_VALID next edge, while OVERRUN stays 1 until reset.
- Reset mid-transfer:
  - Stimulus: BUS_EN rises, RST_n pulsed low at E0+1, BUS_EN returns low during reset.
  - Required: no ENABLE_PULSE after release, and SYNC_BUS=0.

Source files
------------

// File: rtl/data_sync_mcp.sv
// Multi-cycle-path CDC synchroniser: a qualifier crosses through a flop chain, then captures a quasi-static bus.
// Optional held-valid handshake with overrun detection is enabled by defining DATA_SYNC_HOLD_EN.
module data_sync_mcp #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int EN_MODE    = 0
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE
`ifdef DATA_SYNC_HOLD_EN
    ,
    output logic                 SYNC_VALID,
    input  logic                 SYNC_ACK,
    output logic                 OVERRUN
`endif
);

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  en_q, en_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  pulse_q, pulse_d;
    logic                  sync_out;
    logic                  pulse;

    assign sync_out = sync_q[NUM_STAGES-1];

    // Level mode reacts to rising edges only; toggle mode to either edge.
    always_comb begin
        pulse = 1'b0;
        if (EN_MODE == 1) begin
            pulse = sync_out ^ en_q;
        end else begin
            pulse = sync_out & ~en_q;
        end
    end

    always_comb begin
        sync_d  = {sync_q[NUM_STAGES-2:0], BUS_EN};
        en_d    = sync_out;
        bus_d   = bus_q;
        pulse_d = 1'b0;
        if (pulse) begin
            bus_d   = UNSYNC_BUS;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q  <= '0;
            en_q    <= 1'b0;
            bus_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            en_q    <= en_d;
            bus_q   <= bus_d;
            pulse_q <= pulse_d;
        end
    end

    assign SYNC_BUS     = bus_q;
    assign ENABLE_PULSE = pulse_q;

`ifdef DATA_SYNC_HOLD_EN
    logic valid_q, valid_d;
    logic ovr_q, ovr_d;

    // A new word wins over an acknowledge in the same cycle.
    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (pulse) begin
            valid_d = 1'b1;
            if (valid_q && !SYNC_ACK) begin
                ovr_d = 1'b1;
            end
        end else if (SYNC_ACK) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign SYNC_VALID = valid_q;
    assign OVERRUN    = ovr_q;
`endif

endmodule

// File: tb/tb_data_sync_mcp.sv
// Directed bench for data_sync_mcp: level, toggle and depth-sweep instances share one clock and reset.
// Handshake checks are compiled in when DATA_SYNC_HOLD_EN is defined.
module tb_data_sync_mcp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en_l = 1'b0;
    logic [7:0]  d_l = 8'h00;
    logic [7:0]  bus_l;
    logic        p_l;

    logic        en_t = 1'b0;
    logic [7:0]  d_t = 8'h00;
    logic [7:0]  bus_t;
    logic        p_t;

    logic        en_s = 1'b0;
    logic [31:0] d32 = 32'h0;
    logic [0:0]  bus_a;
    logic [31:0] bus_b, bus_c;
    logic        p_a, p_b, p_c;

`ifdef DATA_SYNC_HOLD_EN
    logic       ack_l = 1'b0;
    logic       ack0 = 1'b0;
    logic [4:0] vld, ovr;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_sync_mcp #(.NUM_STAGES(2), .BUS_WIDTH(8), .EN_MODE(0)) u_l2 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(d_l), .BUS_EN(en_l),
        .SYNC_BUS(bus_l), .ENABLE_PULSE(p_l)
`ifdef DATA_SYNC_HOLD_EN
        , .SYNC_VALID(vld[0]), .SYNC_ACK(ack_l), .OVERRUN(ovr[0])
`endif
    );

    data_sync_mcp #(.NUM_STAGES(3), .BUS_WIDTH(8), .EN_MODE(1)) u_t3 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(d_t), .BUS_EN(en_t),
        .SYNC_BUS(bus_t), .ENABLE_PULSE(p_t)
`ifdef DATA_SYNC_HOLD_EN
        , .SYNC_VALID(vld[1]), .SYNC_ACK(ack0), .OVERRUN(ovr[1])
`endif
    );

    data_sync_mcp #(.NUM_STAGES(2), .BUS_WIDTH(1), .EN_MODE(1)) u_d2 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(d32[0:0]), .BUS_EN(en_s),
        .SYNC_BUS(bus_a), .ENABLE_PULSE(p_a)
`ifdef DATA_SYNC_HOLD_EN
        , .SYNC_VALID(vld[2]), .SYNC_ACK(ack0), .OVERRUN(ovr[2])
`endif
    );

    data_sync_mcp #(.NUM_STAGES(4), .BUS_WIDTH(32), .EN_MODE(1)) u_d4 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(d32), .BUS_EN(en_s),
        .SYNC_BUS(bus_b), .ENABLE_PULSE(p_b)
`ifdef DATA_SYNC_HOLD_EN
        , .SYNC_VALID(vld[3]), .SYNC_ACK(ack0), .OVERRUN(ovr[3])
`endif
    );

    data_sync_mcp #(.NUM_STAGES(8), .BUS_WIDTH(32), .EN_MODE(1)) u_d8 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(d32), .BUS_EN(en_s),
        .SYNC_BUS(bus_c), .ENABLE_PULSE(p_c)
`ifdef DATA_SYNC_HOLD_EN
        , .SYNC_VALID(vld[4]), .SYNC_ACK(ack0), .OVERRUN(ovr[4])
`endif
    );

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       p;
        logic [7:0] bus;
    } vec_t;

    vec_t tbl[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_l = 1'b0;
        en_t = 1'b0;
        en_s = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef DATA_SYNC_HOLD_EN
    // Leaves the level instance one edge before its capture edge.
    task automatic send_l(input logic [7:0] d);
        en_l = 1'b0;
        repeat (3) tick();
        d_l = d;
        en_l = 1'b1;
        repeat (2) tick();
    endtask
`endif

    logic [31:0] old_b, old_c, new_w;
    logic        old_a;

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'hA5, 1'b1, 8'hA5};
        tbl[3]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[5]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[6]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[7]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[8]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[9]  = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        tbl[10] = '{1'b0, 8'hFF, 1'b0, 8'hA5};
        tbl[11] = '{1'b0, 8'hFF, 1'b0, 8'hA5};
        tbl[12] = '{1'b0, 8'hFF, 1'b0, 8'hA5};
        tbl[13] = '{1'b1, 8'h3C, 1'b0, 8'hA5};
        tbl[14] = '{1'b1, 8'h3C, 1'b0, 8'hA5};
        tbl[15] = '{1'b1, 8'h3C, 1'b1, 8'h3C};
        tbl[16] = '{1'b1, 8'h3C, 1'b0, 8'h3C};

        // Reset values with all-ones data on the buses
        d_l = 8'hFF;
        d_t = 8'hFF;
        d32 = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst bus_l", {24'h0, bus_l}, 32'h0);
            chk("rst p_l", {31'h0, p_l}, 32'h0);
            chk("rst bus_t", {24'h0, bus_t}, 32'h0);
            chk("rst p_t", {31'h0, p_t}, 32'h0);
            chk("rst bus_a", {31'h0, bus_a}, 32'h0);
            chk("rst bus_b", bus_b, 32'h0);
            chk("rst bus_c", bus_c, 32'h0);
            chk("rst pulses", {29'h0, p_a, p_b, p_c}, 32'h0);
`ifdef DATA_SYNC_HOLD_EN
            chk("rst valid", {27'h0, vld}, 32'h0);
            chk("rst overrun", {27'h0, ovr}, 32'h0);
`endif
        end
        do_reset();

        // Level mode, NUM_STAGES=2
        for (int i = 0; i < 17; i++) begin
            en_l = tbl[i].en;
            d_l = tbl[i].d;
            tick();
            chk($sformatf("lvl[%0d] pulse", i), {31'h0, p_l}, {31'h0, tbl[i].p});
            chk($sformatf("lvl[%0d] bus", i), {24'h0, bus_l}, {24'h0, tbl[i].bus});
        end

        // Toggle mode, NUM_STAGES=3
        for (int w = 0; w < 3; w++) begin
            d_t = 8'h11 * 8'(w + 1);
            en_t = ~en_t;
            for (int k = 1; k <= 5; k++) begin
                tick();
                chk($sformatf("tgl w%0d k%0d pulse", w, k), {31'h0, p_t}, {31'h0, k == 4});
                if (k >= 4)
                    chk($sformatf("tgl w%0d k%0d bus", w, k), {24'h0, bus_t}, {24'h0, 8'h11 * 8'(w + 1)});
            end
        end

        // Depth sweep, 50 random words, toggle qualifier
        old_a = 1'b0;
        old_b = 32'h0;
        old_c = 32'h0;
        for (int w = 0; w < 50; w++) begin
            new_w = $urandom;
            d32 = new_w;
            en_s = ~en_s;
            for (int k = 1; k <= 10; k++) begin
                tick();
                chk($sformatf("d2 w%0d k%0d pulse", w, k), {31'h0, p_a}, {31'h0, k == 3});
                chk($sformatf("d4 w%0d k%0d pulse", w, k), {31'h0, p_b}, {31'h0, k == 5});
                chk($sformatf("d8 w%0d k%0d pulse", w, k), {31'h0, p_c}, {31'h0, k == 9});
                chk($sformatf("d2 w%0d k%0d bus", w, k), {31'h0, bus_a}, {31'h0, (k >= 3) ? new_w[0] : old_a});
                chk($sformatf("d4 w%0d k%0d bus", w, k), bus_b, (k >= 5) ? new_w : old_b);
                chk($sformatf("d8 w%0d k%0d bus", w, k), bus_c, (k >= 9) ? new_w : old_c);
            end
            old_a = new_w[0];
            old_b = new_w;
            old_c = new_w;
        end

        // Reset asserted between E0 and E0+1
        en_l = 1'b0;
        repeat (4) tick();
        d_l = 8'h77;
        en_l = 1'b1;
        tick();
        rst_n = 1'b0;
        en_l = 1'b0;
        repeat (3) tick();
        chk("midrst bus in reset", {24'h0, bus_l}, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("midrst k%0d pulse", k), {31'h0, p_l}, 32'h0);
            chk($sformatf("midrst k%0d bus", k), {24'h0, bus_l}, 32'h0);
        end

`ifdef DATA_SYNC_HOLD_EN
        send_l(8'h5A);
        tick();
        chk("hold 5A bus", {24'h0, bus_l}, 32'h5A);
        chk("hold 5A valid", {31'h0, vld[0]}, 32'h1);
        chk("hold 5A ovr", {31'h0, ovr[0]}, 32'h0);
        send_l(8'h66);
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        chk("hold 66 bus", {24'h0, bus_l}, 32'h66);
        chk("hold 66 valid", {31'h0, vld[0]}, 32'h1);
        chk("hold 66 ovr", {31'h0, ovr[0]}, 32'h0);
        send_l(8'hC3);
        tick();
        chk("hold C3 bus", {24'h0, bus_l}, 32'hC3);
        chk("hold C3 ovr", {31'h0, ovr[0]}, 32'h1);
        chk("hold C3 valid", {31'h0, vld[0]}, 32'h1);
        ack_l = 1'b1;
        tick();
        chk("hold ack valid", {31'h0, vld[0]}, 32'h0);
        chk("hold ack ovr", {31'h0, ovr[0]}, 32'h1);
        tick();
        ack_l = 1'b0;
        chk("hold idle ack valid", {31'h0, vld[0]}, 32'h0);
        repeat (3) tick();
        chk("hold ovr sticky", {31'h0, ovr[0]}, 32'h1);
        do_reset();
        chk("hold ovr after rst", {31'h0, ovr[0]}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
